// File: rtl/ff_bank_inv.sv
// ff_bank_inv: a WIDTH-bit register bank. Each clock edge it can parallel-load,
// shift, rotate or step as a Galois LFSR. It also flags every change of q and
// keeps a saturating count of those changes.
//
// Ports:
//   clk      - single clock, all state updates on the rising edge
//   rst_n    - synchronous active-low reset: q=INIT_VAL, chg=0, chg_cnt=0
//   ce       - clock enable; when low (and sr low) q holds
//   sr       - synchronous clear to CLR_VAL, beats ce and mode
//   mode     - 00 load d^D_INV_MASK, 01 shift-left with sin, 10 rotate-left,
//              11 Galois LFSR (right-shifting, TAPS feedback)
//   d        - parallel load data
//   sin      - serial input for shift mode (also passes through D_INV_MASK[0])
//   q        - register contents
//   sout     - q[WIDTH-1], combinational
//   chg      - registered, high in the cycle q differs from the previous q
//   chg_cnt  - saturating count of cycles with chg=1, cleared only by rst_n
//
// Output timing: q, chg and chg_cnt all update together on the same edge,
// one cycle after the inputs that caused them were sampled. chg acts as a
// per-cycle "new value" strobe; there is no backpressure.
module ff_bank_inv #(
  parameter int unsigned          WIDTH      = 8,
  parameter logic [WIDTH-1:0]     INIT_VAL   = '0,
  parameter logic [WIDTH-1:0]     CLR_VAL    = '0,
  parameter logic [WIDTH-1:0]     D_INV_MASK = '0,
  parameter logic [WIDTH-1:0]     TAPS       = WIDTH'(8'hB8),
  parameter int unsigned          CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             sr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             chg,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [1:0] MODE_LOAD  = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;
  localparam logic [1:0] MODE_LFSR  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_next;
  logic             q_changes;

  // Next-state value for the non-reset case; rst_n is handled in the flop.
  always_comb begin
    q_next = q;
    if (sr) begin
      q_next = CLR_VAL;
    end else if (ce) begin
      case (mode)
        MODE_LOAD:  q_next = d ^ D_INV_MASK;
        MODE_SHIFT: q_next = {q[WIDTH-2:0], sin ^ D_INV_MASK[0]};
        MODE_ROT:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
        MODE_LFSR: begin
          // The all-zero state is a fixed point of the LFSR; seed it with 1.
          if (q == '0) q_next = {{(WIDTH-1){1'b0}}, 1'b1};
          else         q_next = (q >> 1) ^ (q[0] ? TAPS : '0);
        end
        default:    q_next = q;
      endcase
    end
  end

  assign q_changes = (q_next != q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q       <= INIT_VAL;
      chg     <= 1'b0;
      chg_cnt <= '0;
    end else begin
      q   <= q_next;
      chg <= q_changes;
      if (q_changes && (chg_cnt != CNT_MAX)) chg_cnt <= chg_cnt + 1'b1;
    end
  end

  assign sout = q[WIDTH-1];

endmodule

// File: tb/tb_ff_bank_inv.sv
module tb_ff_bank_inv;

  localparam int W = 8;
  localparam int CW = 4;
  localparam int EW = 1 + 1 + CW + W;  // {sout, chg, chg_cnt, q}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b1;
  logic          ce    = 1'b0;
  logic          sr    = 1'b0;
  logic [1:0]    mode  = 2'b00;
  logic [W-1:0]  d     = '0;
  logic          sin   = 1'b0;
  logic [W-1:0]  q;
  logic          sout;
  logic          chg;
  logic [CW-1:0] chg_cnt;

  ff_bank_inv #(
    .WIDTH     (W),
    .INIT_VAL  (8'hA5),
    .CLR_VAL   (8'h00),
    .D_INV_MASK(8'h0F),
    .TAPS      (8'hB8),
    .CNT_W     (CW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce     (ce),
    .sr     (sr),
    .mode   (mode),
    .d      (d),
    .sin    (sin),
    .q      (q),
    .sout   (sout),
    .chg    (chg),
    .chg_cnt(chg_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_total = 0;
  int            n_pass  = 0;

  // Monitor: every edge that has a pending expectation is checked #1 later.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      logic [EW-1:0] a;
      string         nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {sout, chg, chg_cnt, q};
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got sout=%b chg=%b cnt=%0d q=%h, want sout=%b chg=%b cnt=%0d q=%h",
                    nm, a[EW-1], a[EW-2], a[W+CW-1:W], a[W-1:0],
                    e[EW-1], e[EW-2], e[W+CW-1:W], e[W-1:0]);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic rn, input logic s, input logic c,
                      input logic [1:0] m, input logic [W-1:0] dd, input logic si,
                      input logic [W-1:0] eq, input logic ech,
                      input logic [CW-1:0] ecnt, input string nm);
    @(negedge clk);
    rst_n = rn; sr = s; ce = c; mode = m; d = dd; sin = si;
    exp_q.push_back({eq[W-1], ech, ecnt, eq});
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] rot_exp[8];
  logic [W-1:0] dv;

  initial begin
    rot_exp[0] = 8'h02; rot_exp[1] = 8'h04; rot_exp[2] = 8'h08; rot_exp[3] = 8'h10;
    rot_exp[4] = 8'h20; rot_exp[5] = 8'h40; rot_exp[6] = 8'h80; rot_exp[7] = 8'h01;

    repeat (2) @(posedge clk);

    // reset wins over sr and ce
    step(0, 1, 1, 2'b00, 8'hFF, 0, 8'hA5, 0, 4'd0, "reset");
    // load with inversion mask
    step(1, 0, 1, 2'b00, 8'h3C, 0, 8'h33, 1, 4'd1, "load");
    step(1, 0, 1, 2'b00, 8'h3C, 0, 8'h33, 0, 4'd1, "load_same");
    // sr beats ce/load
    step(1, 1, 1, 2'b00, 8'hFF, 0, 8'h00, 1, 4'd2, "sr_prio");
    // hold with ce=0 while d toggles
    step(1, 0, 0, 2'b00, 8'hAA, 1, 8'h00, 0, 4'd2, "hold_a");
    step(1, 0, 0, 2'b11, 8'h55, 0, 8'h00, 0, 4'd2, "hold_b");
    // shift: sin=0 inverted by mask bit 0
    step(1, 0, 1, 2'b01, 8'h00, 0, 8'h01, 1, 4'd3, "shift");
    // rotate eight times
    for (int i = 0; i < 8; i++)
      step(1, 0, 1, 2'b10, 8'h00, 0, rot_exp[i], 1, CW'(4 + i), $sformatf("rot%0d", i));
    // clear then LFSR from zero (cnt 11 -> 12..15)
    step(1, 1, 0, 2'b11, 8'h00, 0, 8'h00, 1, 4'd12, "sr_clr");
    step(1, 0, 1, 2'b11, 8'h00, 0, 8'h01, 1, 4'd13, "lfsr_escape");
    step(1, 0, 1, 2'b11, 8'h00, 0, 8'hB8, 1, 4'd14, "lfsr1");
    step(1, 0, 1, 2'b11, 8'h00, 0, 8'h5C, 1, 4'd15, "lfsr2");
    // 20 changing loads: counter stays saturated
    for (int i = 0; i < 20; i++) begin
      dv = (i % 2 == 0) ? 8'h00 : 8'hFF;
      step(1, 0, 1, 2'b00, dv, 0, dv ^ 8'h0F, 1, 4'd15, $sformatf("sat%0d", i));
    end
    // LFSR run from F0, then reset mid-run
    step(1, 0, 1, 2'b11, 8'h00, 0, 8'h78, 1, 4'd15, "lfsr_run0");
    step(1, 0, 1, 2'b11, 8'h00, 0, 8'h3C, 1, 4'd15, "lfsr_run1");
    step(0, 0, 1, 2'b11, 8'h00, 0, 8'hA5, 0, 4'd0, "mid_reset");
    step(1, 0, 1, 2'b11, 8'h00, 0, 8'hEA, 1, 4'd1, "lfsr_after_rst");

    // drain the scoreboard with a bounded wait
    begin
      int budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_total++;
        $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
